// File: rtl/cache_sa_wb_pkg.sv
// Shared bus widths, cache FSM state type and default cache geometry.
package PARAMS_pkg;
  localparam int unsigned ADDR_SIZE = 32;
  localparam int unsigned WD_SIZE   = 32;

  localparam int unsigned DEF_LINE_BYTES = 64;
  localparam int unsigned DEF_NUM_SETS   = 4;
  localparam int unsigned DEF_NUM_WAYS   = 2;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, RESPOND} cache_state_t;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction
endpackage

// File: rtl/cache_sa_wb_lru.sv
// cache_lru: per-set age-based LRU with hit/fill update and victim selection.
module cache_lru import PARAMS_pkg::*; #(
  parameter int unsigned NUM_SETS = DEF_NUM_SETS,
  parameter int unsigned NUM_WAYS = DEF_NUM_WAYS,
  localparam int unsigned SETW = clog2_min1(NUM_SETS),
  localparam int unsigned WAYW = clog2_min1(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SETW-1:0]     i_set,
  input  logic [NUM_WAYS-1:0] i_valid,
  output logic [WAYW-1:0]     o_victim,
  input  logic                i_upd,
  input  logic [SETW-1:0]     i_upd_set,
  input  logic [WAYW-1:0]     i_upd_way
);
  generate
    if (NUM_WAYS == 1) begin : g_dm
      assign o_victim = '0;
    end else begin : g_lru
      logic [WAYW-1:0] r_age [NUM_SETS][NUM_WAYS];
      logic            w_found;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned s = 0; s < NUM_SETS; s++)
            for (int unsigned w = 0; w < NUM_WAYS; w++)
              r_age[s][w] <= WAYW'(w);
        end else if (i_upd) begin
          for (int unsigned w = 0; w < NUM_WAYS; w++)
            if (r_age[i_upd_set][w] < r_age[i_upd_set][i_upd_way])
              r_age[i_upd_set][w] <= r_age[i_upd_set][w] + 1'b1;
          r_age[i_upd_set][i_upd_way] <= '0;
        end
      end

      // Invalid ways are filled first (lowest index wins), otherwise the oldest way.
      always_comb begin
        o_victim = '0;
        w_found  = 1'b0;
        for (int unsigned w = 0; w < NUM_WAYS; w++)
          if (!w_found && !i_valid[w]) begin
            o_victim = WAYW'(w);
            w_found  = 1'b1;
          end
        if (!w_found)
          for (int unsigned w = 0; w < NUM_WAYS; w++)
            if (r_age[i_set][w] == WAYW'(NUM_WAYS - 1))
              o_victim = WAYW'(w);
      end
    end
  endgenerate
endmodule

// File: rtl/cache_sa_wb.sv
// cache_sa_wb: N-way set-associative write-back/write-allocate data cache.
// Single-cycle hits; misses run a blocking writeback/refill sequence over a req/ack port.
module cache_sa_wb import PARAMS_pkg::*; #(
  parameter int unsigned LINE_BYTES = DEF_LINE_BYTES,
  parameter int unsigned NUM_SETS   = DEF_NUM_SETS,
  parameter int unsigned NUM_WAYS   = DEF_NUM_WAYS,
  parameter int unsigned LINE_BITS  = LINE_BYTES * 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid_i,
  input  logic                 req_we_i,
  input  logic [ADDR_SIZE-1:0] req_addr_i,
  input  logic [WD_SIZE-1:0]   req_wdata_i,
  output logic                 rsp_valid_o,
  output logic [WD_SIZE-1:0]   rsp_rdata_o,
  output logic                 stall_cache_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [ADDR_SIZE-1:0] mem_addr_o,
  output logic [LINE_BITS-1:0] mem_wdata_o,
  input  logic                 mem_ack_i,
  input  logic [LINE_BITS-1:0] mem_rdata_i
);
  localparam int unsigned OFFSET_BITS = $clog2(LINE_BYTES);
  localparam int unsigned INDEX_BITS  = $clog2(NUM_SETS);
  localparam int unsigned TAG_BITS    = ADDR_SIZE - OFFSET_BITS - INDEX_BITS;
  localparam int unsigned WAYW        = clog2_min1(NUM_WAYS);
  localparam int unsigned BYTE_BITS   = $clog2(WD_SIZE / 8);

  cache_state_t r_state;
  logic [TAG_BITS-1:0]  r_tag  [NUM_SETS][NUM_WAYS];
  logic [LINE_BITS-1:0] r_data [NUM_SETS][NUM_WAYS];
  logic [NUM_SETS-1:0][NUM_WAYS-1:0] r_valid, r_dirty;
  logic [ADDR_SIZE-1:0] r_addr;
  logic                 r_we;
  logic [WD_SIZE-1:0]   r_wdata;
  logic [WAYW-1:0]      r_vict;
  logic                 r_rsp_valid, r_mem_req, r_mem_we;
  logic [WD_SIZE-1:0]   r_rsp_rdata;
  logic [ADDR_SIZE-1:0] r_mem_addr;
  logic [LINE_BITS-1:0] r_mem_wdata;

  logic [TAG_BITS-1:0]    w_req_tag, w_q_tag;
  logic [INDEX_BITS-1:0]  w_req_idx, w_q_idx;
  logic [OFFSET_BITS-1:0] w_req_wsel, w_q_wsel;
  logic                   w_hit, w_lru_upd;
  logic [WAYW-1:0]        w_hit_way, w_victim, w_lru_way;
  logic [INDEX_BITS-1:0]  w_lru_set;
  logic [WD_SIZE-1:0]     w_hit_word;
  logic [LINE_BITS-1:0]   w_fill_line;

  assign w_req_tag  = req_addr_i[ADDR_SIZE-1 -: TAG_BITS];
  assign w_req_idx  = req_addr_i[OFFSET_BITS +: INDEX_BITS];
  assign w_req_wsel = req_addr_i[OFFSET_BITS-1:0] >> BYTE_BITS;
  assign w_q_tag    = r_addr[ADDR_SIZE-1 -: TAG_BITS];
  assign w_q_idx    = r_addr[OFFSET_BITS +: INDEX_BITS];
  assign w_q_wsel   = r_addr[OFFSET_BITS-1:0] >> BYTE_BITS;

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++)
      if (r_valid[w_req_idx][w] && r_tag[w_req_idx][w] == w_req_tag) begin
        w_hit     = 1'b1;
        w_hit_way = WAYW'(w);
      end
  end

  assign w_hit_word = r_data[w_req_idx][w_hit_way][w_req_wsel*WD_SIZE +: WD_SIZE];

  // Write misses merge the store word into the incoming line as it is installed.
  always_comb begin
    w_fill_line = mem_rdata_i;
    if (r_we) w_fill_line[w_q_wsel*WD_SIZE +: WD_SIZE] = r_wdata;
  end

  assign w_lru_upd = (r_state == IDLE && req_valid_i && w_hit) || (r_state == RESPOND);
  assign w_lru_set = (r_state == RESPOND) ? w_q_idx : w_req_idx;
  assign w_lru_way = (r_state == RESPOND) ? r_vict : w_hit_way;

  cache_lru #(.NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS)) u_lru (
    .clk       (clk),
    .rst_n     (reset_n),
    .i_set     (w_req_idx),
    .i_valid   (r_valid[w_req_idx]),
    .o_victim  (w_victim),
    .i_upd     (w_lru_upd),
    .i_upd_set (w_lru_set),
    .i_upd_way (w_lru_way)
  );

  always_ff @(posedge clk) begin
    if (r_state == IDLE && req_valid_i && w_hit && req_we_i)
      r_data[w_req_idx][w_hit_way][w_req_wsel*WD_SIZE +: WD_SIZE] <= req_wdata_i;
    if (r_state == REFILL && mem_ack_i) begin
      r_data[w_q_idx][r_vict] <= w_fill_line;
      r_tag[w_q_idx][r_vict]  <= w_q_tag;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_valid     <= '0;
      r_dirty     <= '0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_vict      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      unique case (r_state)
        IDLE: if (req_valid_i) begin
          if (w_hit) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= req_we_i ? '0 : w_hit_word;
            if (req_we_i) r_dirty[w_req_idx][w_hit_way] <= 1'b1;
          end else begin
            r_addr    <= req_addr_i;
            r_we      <= req_we_i;
            r_wdata   <= req_wdata_i;
            r_vict    <= w_victim;
            r_mem_req <= 1'b1;
            if (r_valid[w_req_idx][w_victim] && r_dirty[w_req_idx][w_victim]) begin
              r_state     <= WRITEBACK;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= {r_tag[w_req_idx][w_victim], w_req_idx, {OFFSET_BITS{1'b0}}};
              r_mem_wdata <= r_data[w_req_idx][w_victim];
            end else begin
              r_state    <= REFILL;
              r_mem_we   <= 1'b0;
              r_mem_addr <= {w_req_tag, w_req_idx, {OFFSET_BITS{1'b0}}};
            end
          end
        end
        WRITEBACK: if (mem_ack_i) begin
          r_dirty[w_q_idx][r_vict] <= 1'b0;
          r_state     <= REFILL;
          r_mem_we    <= 1'b0;
          r_mem_addr  <= {w_q_tag, w_q_idx, {OFFSET_BITS{1'b0}}};
          r_mem_wdata <= '0;
        end
        REFILL: if (mem_ack_i) begin
          r_valid[w_q_idx][r_vict] <= 1'b1;
          r_dirty[w_q_idx][r_vict] <= r_we;
          r_mem_req   <= 1'b0;
          r_mem_addr  <= '0;
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= r_we ? '0 : w_fill_line[w_q_wsel*WD_SIZE +: WD_SIZE];
          r_state     <= RESPOND;
        end
        RESPOND: r_state <= IDLE;
      endcase
    end
  end

  assign stall_cache_o = (r_state != IDLE);
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_rdata_o   = r_rsp_rdata;
  assign mem_req_o     = r_mem_req;
  assign mem_we_o      = r_mem_we;
  assign mem_addr_o    = r_mem_addr;
  assign mem_wdata_o   = r_mem_wdata;
endmodule

// File: tb/tb_cache_sa_wb.sv
// Randomized self-checking bench for cache_sa_wb against a recency-list cache model
// and a sparse line-addressed memory.
`timescale 1ns/1ps
module tb_cache_sa_wb;
  import PARAMS_pkg::*;
  localparam int unsigned LBYTES = 64;
  localparam int unsigned SETS   = 4;
  localparam int unsigned WAYS   = 2;
  localparam int unsigned LB     = LBYTES * 8;

  logic clk = 1'b0, reset_n = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic rsp_valid_o, stall_cache_o, mem_req_o, mem_we_o;
  logic [31:0] rsp_rdata_o, mem_addr_o;
  logic [LB-1:0] mem_wdata_o;
  logic mem_ack = 1'b0;
  logic [LB-1:0] mem_rdata = '0;

  cache_sa_wb #(.LINE_BYTES(LBYTES), .NUM_SETS(SETS), .NUM_WAYS(WAYS)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .stall_cache_o(stall_cache_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int txn_count = 0;
  bit chk_en = 1'b0;

  logic          exp_stall = 1'b0, exp_rsp_v = 1'b0, exp_mreq = 1'b0, exp_mwe = 1'b0;
  logic [31:0]   exp_rdata = '0, exp_maddr = '0;
  logic [LB-1:0] exp_mwdata = '0;

  logic [31:0]   cap_rdata, cap_wb_addr, cap_rf_addr;
  logic [LB-1:0] cap_wb_data;

  // Model: line-addressed memory plus per-set ways kept in recency order (front = most recent).
  logic [LB-1:0] mem [int unsigned];
  bit            m_valid [SETS][WAYS];
  bit            m_dirty [SETS][WAYS];
  int unsigned   m_tag   [SETS][WAYS];
  logic [LB-1:0] m_line  [SETS][WAYS];
  int            m_order [SETS][$];

  task automatic chk(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("stall", LB'(stall_cache_o), LB'(exp_stall));
    chk("rsp_valid", LB'(rsp_valid_o), LB'(exp_rsp_v));
    if (exp_rsp_v) chk("rsp_rdata", LB'(rsp_rdata_o), LB'(exp_rdata));
    chk("mem_req", LB'(mem_req_o), LB'(exp_mreq));
    if (exp_mreq) begin
      chk("mem_we", LB'(mem_we_o), LB'(exp_mwe));
      chk("mem_addr", LB'(mem_addr_o), LB'(exp_maddr));
      if (exp_mwe) chk("mem_wdata", mem_wdata_o, exp_mwdata);
    end
  end

  function automatic logic [LB-1:0] mem_line(input int unsigned a);
    logic [LB-1:0] l;
    if (!mem.exists(a)) begin
      for (int i = 0; i < int'(LB / 32); i++) l[i*32 +: 32] = $urandom;
      mem[a] = l;
    end
    return mem[a];
  endfunction

  task automatic model_reset();
    for (int s = 0; s < int'(SETS); s++) begin
      m_order[s].delete();
      for (int w = 0; w < int'(WAYS); w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_order[s].push_back(w);
      end
    end
  endtask

  task automatic touch(input int s, input int way);
    int pos = 0;
    for (int i = 0; i < m_order[s].size(); i++) if (m_order[s][i] == way) pos = i;
    m_order[s].delete(pos);
    m_order[s].push_front(way);
  endtask

  task automatic model_access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                              output bit hit, output logic [31:0] rd, output bit wb,
                              output logic [31:0] wb_a, output logic [LB-1:0] wb_d,
                              output logic [31:0] rf_a, output logic [LB-1:0] rf_d);
    int unsigned s  = (addr / LBYTES) % SETS;
    int unsigned tg = addr / (LBYTES * SETS);
    int unsigned wi = (addr % LBYTES) / 4;
    int way = -1;
    for (int w = 0; w < int'(WAYS); w++) if (m_valid[s][w] && m_tag[s][w] == tg) way = w;
    hit = (way >= 0); wb = 1'b0; rd = '0; wb_a = '0; wb_d = '0; rf_d = '0;
    rf_a = addr - (addr % LBYTES);
    if (!hit) begin
      for (int w = int'(WAYS) - 1; w >= 0; w--) if (!m_valid[s][w]) way = w;
      if (way < 0) way = m_order[s][$];
      if (m_valid[s][way] && m_dirty[s][way]) begin
        wb = 1'b1;
        wb_a = (m_tag[s][way] * SETS + s) * LBYTES;
        wb_d = m_line[s][way];
        mem[wb_a] = wb_d;
      end
      rf_d = mem_line(rf_a);
      m_line[s][way] = rf_d; m_tag[s][way] = tg; m_valid[s][way] = 1'b1; m_dirty[s][way] = 1'b0;
    end
    if (we) begin
      m_line[s][way][wi*32 +: 32] = wd;
      m_dirty[s][way] = 1'b1;
    end else rd = m_line[s][way][wi*32 +: 32];
    touch(s, way);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic handshake(input logic [LB-1:0] line, output logic [31:0] a, output logic [LB-1:0] d);
    repeat ($urandom_range(0, 3)) step();
    mem_ack = 1'b1; mem_rdata = line;
    a = mem_addr_o; d = mem_wdata_o;
    txn_count++;
    step();
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  // Hits return in the response cycle so a following access issues back-to-back.
  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd);
    bit hit, wb;
    logic [31:0] rd, wb_a, rf_a;
    logic [LB-1:0] wb_d, rf_d, dummy;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    model_access(we, addr, wd, hit, rd, wb, wb_a, wb_d, rf_a, rf_d);
    step();
    if (hit) begin
      req_valid = 1'b0;
      exp_rsp_v = 1'b1; exp_rdata = rd; exp_stall = 1'b0; exp_mreq = 1'b0;
      cap_rdata = rsp_rdata_o;
      return;
    end
    exp_rsp_v = 1'b0; exp_stall = 1'b1;
    if (wb) begin
      exp_mreq = 1'b1; exp_mwe = 1'b1; exp_maddr = wb_a; exp_mwdata = wb_d;
      handshake('0, cap_wb_addr, cap_wb_data);
    end
    exp_mreq = 1'b1; exp_mwe = 1'b0; exp_maddr = rf_a;
    handshake(rf_d, cap_rf_addr, dummy);
    req_valid = 1'b0;
    exp_mreq = 1'b0; exp_rsp_v = 1'b1; exp_rdata = rd;
    cap_rdata = rsp_rdata_o;
    step();
    exp_rsp_v = 1'b0; exp_stall = 1'b0;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    mem_ack = ($urandom_range(0, 3) == 0);
    mem_rdata = {16{$urandom}};
    step();
    mem_ack = 1'b0;
    exp_rsp_v = 1'b0; exp_stall = 1'b0; exp_mreq = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_stall"}, LB'(stall_cache_o), '0);
    chk({nm, "_rsp_valid"}, LB'(rsp_valid_o), '0);
    chk({nm, "_rsp_rdata"}, LB'(rsp_rdata_o), '0);
    chk({nm, "_mem_req"}, LB'(mem_req_o), '0);
    chk({nm, "_mem_we"}, LB'(mem_we_o), '0);
    chk({nm, "_mem_addr"}, LB'(mem_addr_o), '0);
    chk({nm, "_mem_wdata"}, mem_wdata_o, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    logic [31:0] a;
    logic [LB-1:0] l;
    model_reset();
    repeat (2) step();
    chk_all_zero("reset");
    reset_n = 1'b1;
    step();
    chk_en = 1'b1;

    l = mem_line(32'h100); l[31:0] = 32'hDEADBEEF; mem[32'h100] = l;
    access(1'b0, 32'h100, '0);
    chk("first_refill_addr", LB'(cap_rf_addr), LB'(32'h100));
    chk("first_miss_data", LB'(cap_rdata), LB'(32'hDEADBEEF));
    t = txn_count;
    access(1'b0, 32'h100, '0);
    chk("reread_hit_data", LB'(cap_rdata), LB'(32'hDEADBEEF));
    access(1'b1, 32'h104, 32'h12345678);
    access(1'b0, 32'h104, '0);
    chk("write_hit_readback", LB'(cap_rdata), LB'(32'h12345678));
    chk("hits_no_mem_txn", LB'(txn_count - t), '0);
    idle();

    access(1'b0, 32'h200, '0);
    access(1'b0, 32'h300, '0);
    chk("evict_wb_addr", LB'(cap_wb_addr), LB'(32'h100));
    chk("evict_wb_word1", LB'(cap_wb_data[63:32]), LB'(32'h12345678));
    chk("evict_refill_addr", LB'(cap_rf_addr), LB'(32'h300));
    t = txn_count;
    access(1'b0, 32'h200, '0);
    chk("survivor_hits", LB'(txn_count - t), '0);
    idle();

    t = txn_count;
    access(1'b1, 32'h440, 32'hCAFEF00D);
    chk("write_miss_one_txn", LB'(txn_count - t), LB'(1));
    chk("write_miss_refill_addr", LB'(cap_rf_addr), LB'(32'h440));
    access(1'b0, 32'h540, '0);
    access(1'b0, 32'h640, '0);
    chk("write_miss_wb_addr", LB'(cap_wb_addr), LB'(32'h440));
    chk("write_miss_wb_word0", LB'(cap_wb_data[31:0]), LB'(32'hCAFEF00D));

    access(1'b0, 32'h100, '0);
    access(1'b0, 32'h100, '0);
    chk("burst0", LB'(cap_rdata), LB'(32'hDEADBEEF));
    access(1'b0, 32'h104, '0);
    chk("burst1", LB'(cap_rdata), LB'(32'h12345678));
    access(1'b0, 32'h108, '0);
    idle();

    for (int n = 0; n < 400; n++) begin
      a = ($urandom_range(0, 5) << 8) | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      if ($urandom_range(0, 2) == 0) idle();
      access(1'(($urandom_range(0, 1))), a, $urandom);
    end
    idle();

    chk_en = 1'b0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    model_reset();
    exp_stall = 1'b0; exp_rsp_v = 1'b0; exp_mreq = 1'b0;
    step();
    chk_en = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100;
    chk_en = 1'b0;
    step();
    chk("midrefill_stall", LB'(stall_cache_o), LB'(1));
    chk("midrefill_req", LB'(mem_req_o), LB'(1));
    chk("midrefill_we", LB'(mem_we_o), '0);
    chk("midrefill_addr", LB'(mem_addr_o), LB'(32'h100));
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    req_valid = 1'b0;
    step();
    reset_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = {16{$urandom}};
    step();
    mem_ack = 1'b0;
    chk("stale_ack_stall", LB'(stall_cache_o), '0);
    chk("stale_ack_rsp", LB'(rsp_valid_o), '0);
    chk("stale_ack_req", LB'(mem_req_o), '0);
    step();
    chk("stale_ack_rsp_later", LB'(rsp_valid_o), '0);
    chk_en = 1'b1;
    t = txn_count;
    access(1'b0, 32'h100, '0);
    chk("post_reset_miss_txn", LB'(txn_count - t), LB'(1));
    chk("post_reset_refill_addr", LB'(cap_rf_addr), LB'(32'h100));
    idle();
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cache_sa_wb.md
Name: cache_sa_wb

Overview:
Parametrised N-way set-associative, write-back, write-allocate data cache. It sits between the core's load/store unit and the memory/TLB port. Hits are serviced in one cycle, with back-to-back hits sustained. Misses are handled by a blocking FSM: optional dirty-victim writeback, then a line refill, over a req/ack memory handshake.

Parameters:
LINE_BYTES, 64, bytes per line (power of 2, at least WD_SIZE/8)
NUM_SETS, 4, sets (power of 2)
NUM_WAYS, 2, associativity (power of 2, 1 allowed = direct-mapped)
LINE_BITS, LINE_BYTES*8, line width
OFFSET_BITS, clog2(LINE_BYTES), byte-offset field
INDEX_BITS, clog2(NUM_SETS), set-index field
TAG_BITS, ADDR_SIZE-OFFSET_BITS-INDEX_BITS, tag field

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid_i  in  1  access request
req_we_i  in  1  1=write, 0=read
req_addr_i  in  ADDR_SIZE  byte address, word-aligned
req_wdata_i  in  WD_SIZE  store data
rsp_valid_o  out  1  one-cycle pulse: access complete
rsp_rdata_o  out  WD_SIZE  load data, valid with rsp_valid_o (0 for writes)
stall_cache_o  out  1  cache busy, request not accepted
mem_req_o  out  1  memory transaction request
mem_we_o  out  1  1=writeback, 0=refill
mem_addr_o  out  ADDR_SIZE  line-aligned address (offset bits 0)
mem_wdata_o  out  LINE_BITS  writeback line
mem_ack_i  in  1  one-cycle completion of current transaction
mem_rdata_i  in  LINE_BITS  refill line, valid with mem_ack_i

Behaviour:
- Address split: tag=[ADDR_SIZE-1 -: TAG_BITS], index=[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS], word select=offset[OFFSET_BITS-1:log2(WD_SIZE/8)].
- Reset (async): state=IDLE, all valid/dirty=0, way ages[w]=w in every set. All outputs 0. Tag/data arrays are not reset.
- stall_cache_o = (state != IDLE). A request is accepted when req_valid_i && state==IDLE.
- FSM states: IDLE, WRITEBACK, REFILL, RESPOND.
- IDLE, hit (valid && tag match in any way): read returns the word on rsp_rdata_o with rsp_valid_o high the next cycle. A write merges the word, sets dirty, and pulses rsp_valid_o the next cycle. LRU is updated. State stays IDLE, so one hit is sustained per cycle.
- IDLE, miss: latch addr/we/wdata and select the victim. Victim = lowest-index invalid way, else the way with age NUM_WAYS-1. Next state = WRITEBACK if victim valid && dirty, else REFILL.
- WRITEBACK: mem_req_o=1, mem_we_o=1, mem_addr_o={victim tag, index, 0}, mem_wdata_o=victim line. Signals are held stable until mem_ack_i. On ack: clear the dirty bit and go to REFILL.
- REFILL: mem_req_o=1, mem_we_o=0, mem_addr_o={req tag, index, 0}. On ack: write mem_rdata_i into the victim way, tag=req tag, valid=1, dirty=0. For a write miss, merge the word in the same cycle and set dirty=1. Go to RESPOND.
- A cycle with ack ends a transaction. A request asserted in the next cycle, including the WRITEBACK->REFILL transition, is a new transaction.
- RESPOND: rsp_valid_o=1 for exactly one cycle, rsp_rdata_o=the refilled/merged word, LRU updated. Go to IDLE.
- Miss latency with no writeback is ack cycle +1. A dirty eviction adds one full handshake.
- LRU update on access to way h: ways with age < age[h] increment, age[h]=0. Ages remain a permutation of 0..NUM_WAYS-1. NUM_WAYS=1 means no age state.
- mem_ack_i is ignored in IDLE and RESPOND. req_valid_i is ignored while stalled; the requester must hold it.
- Reset mid-miss: the FSM returns to IDLE immediately and the in-flight transaction is abandoned. A stale ack after reset is ignored.

Decomposition:
- PARAMS_pkg: ADDR_SIZE, WD_SIZE (existing). Add cache_state_t enum (IDLE, WRITEBACK, REFILL, RESPOND) and the default cache geometry constants.
- Sub-module cache_lru: per-set age array with hit/fill update and victim select, parametrised by NUM_SETS/NUM_WAYS.

Test Plan:
- Reset; read 0x0000_0100 -> stall_cache_o=1, mem_req_o=1, mem_we_o=0, mem_addr_o=0x100. Ack with word0=0xDEADBEEF -> next cycle rsp_valid_o=1, rsp_rdata_o=0xDEADBEEF. Re-read 0x100 -> hit, response 1 cycle later, no mem_req_o.
- After the above, write 0x104=0x12345678 then read 0x104 -> rsp_rdata_o=0x12345678, zero memory transactions.
- Set 0, 2 ways: dirty 0x100, then read 0x200, then read 0x300 -> WRITEBACK mem_addr_o=0x100 with word1=0x12345678, then REFILL mem_addr_o=0x300. A later read of 0x200 hits.
- Write miss 0x440=0xCAFEF00D -> single refill of 0x440, rsp_valid_o pulse. Evicting that line later writes back a line containing 0xCAFEF00D at word0.
- Reads to 0x100, 0x104, 0x108 on consecutive cycles after fill -> rsp_valid_o high 3 consecutive cycles with correct data, stall_cache_o=0 throughout.
- Assert reset_n=0 mid-REFILL -> all outputs 0 immediately. Ack after release is ignored. Read 0x100 -> misses (valid cleared).
